ofs_plat_host_chan_tx_tlp_arb: RTL and testbench
================================================

Name: ofs_plat_host_chan_tx_tlp_arb

Overview:
- Packet-level arbiter that merges N TX TLP sources onto the single host-channel TX TLP stream feeding the FIU edge.
- Typical sources: MMIO read completions, AFU read requests, AFU write requests.
- Round-robin between sources at packet boundaries. Grant stays locked to one source for every beat of a multi-beat packet, so write payload beats are never interleaved.
- Output is registered, one cycle of latency, full throughput.

Parameters:
- NUM_SRC, 3, number of requesting sources (2..8). Index 0 is first in reset priority order.
- DATA_W, 512, width of one beat of TLP data and tuser, concatenated.
- SRC_IDX_W, $clog2(NUM_SRC), width of the source index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_SRC  per-source beat valid.
- in_ready  out  NUM_SRC  per-source beat accepted. May depend combinationally on in_valid.
- in_data  in  NUM_SRC*DATA_W  per-source beat. Source i occupies bits [i*DATA_W +: DATA_W].
- in_sop  in  NUM_SRC  per-source first beat of packet.
- in_eop  in  NUM_SRC  per-source last beat of packet.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output beat.
- out_data  out  DATA_W  output beat.
- out_sop  out  1  first beat of output packet.
- out_eop  out  1  last beat of output packet.
- out_src  out  SRC_IDX_W  index of the source that produced the output beat.
- protocol_err  out  1  sticky error: an unlocked accepted beat had sop=0.

Behaviour:
- Reset values: out_valid=0, out_sop=0, out_eop=0, out_src=0, out_data=0, protocol_err=0, locked=0, lock_src=0, rr_ptr=0. While reset=1, in_ready=0.
- can_load = !out_valid || out_ready. Output register is 1 entry: a beat is loaded on any cycle with can_load=1 and an accepted input.
- Two states:
  - UNLOCKED: winner = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_SRC. in_ready[winner] = can_load. All other in_ready are 0.
  - LOCKED: in_ready[lock_src] = can_load. All other in_ready are 0, even if valid.
- Accepting a beat means in_valid[i] && in_ready[i]. On accept: out_data/out_sop/out_eop/out_src are loaded from source i and out_valid=1 next cycle.
- On a cycle with can_load=1 and no accept: out_valid=0 next cycle.
- Transitions:
  - UNLOCKED, accept with eop=0: go to LOCKED, lock_src=i.
  - UNLOCKED, accept with sop=1 and eop=1: stay UNLOCKED, rr_ptr=(i+1) mod NUM_SRC.
  - LOCKED, accept with eop=1: go to UNLOCKED, rr_ptr=(lock_src+1) mod NUM_SRC.
  - LOCKED, accept with eop=0: stay LOCKED.
- rr_ptr changes only on eop. Wrap: when i=NUM_SRC-1, rr_ptr becomes 0.
- In LOCKED, in_sop is ignored and passed through to out_sop unchanged.
- In UNLOCKED, an accepted beat with sop=0 sets protocol_err=1. The beat is still forwarded and the lock rules above still apply. protocol_err clears only on reset.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and the output holds stable. No beat is dropped or duplicated.
- Throughput: with out_ready held at 1, one beat per cycle is accepted. Back-to-back packets from different sources need no bubble.
- Reset mid-packet: the lock is discarded and the output register cleared. Sources must restart their packets from sop.

Test Plan:
- Single source: src1 sends 4 single-beat packets (sop=eop=1), out_ready=1 -> out_valid on cycles 1..4 after the first accept, out_src=1 on every beat, data in order.
- Fairness: src0, src1, src2 each continuously valid with single-beat packets, from reset -> out_src sequence 0,1,2,0,1,2.
- Lock: src2 sends a 3-beat packet while src0 is valid with 1-beat packets -> output src2 b0, b1, b2 contiguous, then src0. in_ready[0]=0 during the src2 beats.
- Backpressure: out_ready=0 for 5 cycles during a src1 4-beat packet -> out_data stable and in_ready all 0 throughout. After release, remaining beats follow in order with no loss.
- Protocol error: with UNLOCKED, src0 sends a beat with sop=0, eop=1 -> beat forwarded, protocol_err=1 from next cycle and held until reset.
- Reset mid-packet: reset asserted after beat 1 of a 3-beat src1 packet -> out_valid=0, next winner chosen from rr_ptr=0, protocol_err=0.

Source files
------------

// File: rtl/ofs_plat_host_chan_tx_tlp_arb.sv
// Purpose : packet-level round-robin arbiter merging NUM_SRC TX TLP sources onto one host-channel TX stream.
// Latency : one cycle from accepted input beat to registered output beat; one beat per cycle sustained.
// Backpressure: a stalled output register (out_valid && !out_ready) drops every in_ready and holds the output stable.
//
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   in_valid/in_ready[NUM_SRC]      - per-source beat handshake (in_ready may depend on in_valid)
//   in_data[NUM_SRC*DATA_W]         - per-source beat, source i at [i*DATA_W +: DATA_W]
//   in_sop/in_eop[NUM_SRC]          - per-source packet delimiters
//   out_valid/out_ready             - output beat handshake
//   out_data/out_sop/out_eop        - registered output beat and delimiters
//   out_src                         - index of the source that produced the output beat
//   protocol_err                    - sticky: a packet-starting beat arrived without sop
module ofs_plat_host_chan_tx_tlp_arb #(
  parameter int NUM_SRC   = 3,
  parameter int DATA_W    = 512,
  parameter int SRC_IDX_W = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [NUM_SRC-1:0]        in_valid,
  output logic [NUM_SRC-1:0]        in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  input  logic [NUM_SRC-1:0]        in_sop,
  input  logic [NUM_SRC-1:0]        in_eop,

  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [SRC_IDX_W-1:0]      out_src,

  output logic                      protocol_err
);

  // Round-robin successor with explicit wrap so non-power-of-two NUM_SRC works.
  function automatic logic [SRC_IDX_W-1:0] next_idx(input logic [SRC_IDX_W-1:0] i);
    if (i == SRC_IDX_W'(NUM_SRC - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 locked_q,       locked_d;
  logic [SRC_IDX_W-1:0] lock_src_q,     lock_src_d;
  logic [SRC_IDX_W-1:0] rr_ptr_q,       rr_ptr_d;
  logic                 out_valid_q,    out_valid_d;
  logic [DATA_W-1:0]    out_data_q,     out_data_d;
  logic                 out_sop_q,      out_sop_d;
  logic                 out_eop_q,      out_eop_d;
  logic [SRC_IDX_W-1:0] out_src_q,      out_src_d;
  logic                 protocol_err_q, protocol_err_d;

  // ---------------------------------------------------------------------------
  // Winner search: first valid source starting at rr_ptr, wrapping modulo NUM_SRC.
  // ---------------------------------------------------------------------------
  logic                 win_found;
  logic [SRC_IDX_W-1:0] win_idx;
  logic [SRC_IDX_W:0]   cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_IDX_W+1)'(k);
      if (cand >= (SRC_IDX_W+1)'(NUM_SRC)) begin
        cand = cand - (SRC_IDX_W+1)'(NUM_SRC);
      end
      if (!win_found && in_valid[cand[SRC_IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[SRC_IDX_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Selected source and handshake
  // ---------------------------------------------------------------------------
  logic                 can_load;
  logic                 sel_has;   // a source is entitled to the output this cycle
  logic [SRC_IDX_W-1:0] sel_idx;
  logic                 sel_vld;
  logic                 sel_sop;
  logic                 sel_eop;
  logic [DATA_W-1:0]    sel_dat;
  logic                 accept;

  always_comb begin
    can_load = !out_valid_q || out_ready;

    // While locked the lock holder owns the output whether or not it is valid,
    // so a competing source can never slip a beat into the middle of a packet.
    sel_idx  = locked_q ? lock_src_q : win_idx;
    sel_has  = locked_q || win_found;
    sel_vld  = in_valid[sel_idx];
    sel_sop  = in_sop[sel_idx];
    sel_eop  = in_eop[sel_idx];

    sel_dat  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_idx == SRC_IDX_W'(i)) begin
        sel_dat = in_data[i*DATA_W +: DATA_W];
      end
    end

    in_ready = '0;
    if (!reset && can_load && sel_has) begin
      in_ready[sel_idx] = 1'b1;
    end

    accept = !reset && can_load && sel_has && sel_vld;
  end

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    locked_d       = locked_q;
    lock_src_d     = lock_src_q;
    rr_ptr_d       = rr_ptr_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_sop_d      = out_sop_q;
    out_eop_d      = out_eop_q;
    out_src_d      = out_src_q;
    protocol_err_d = protocol_err_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_dat;
      out_sop_d   = sel_sop;
      out_eop_d   = sel_eop;
      out_src_d   = sel_idx;
    end else if (can_load) begin
      // Previous beat drained (or never existed) and nothing replaces it.
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (!locked_q) begin
        // Every unlocked beat starts a packet; flag a missing sop but still
        // forward the beat and apply the normal lock rules.
        if (!sel_sop) begin
          protocol_err_d = 1'b1;
        end
        if (sel_eop) begin
          rr_ptr_d = next_idx(sel_idx);
        end else begin
          locked_d   = 1'b1;
          lock_src_d = sel_idx;
        end
      end else if (sel_eop) begin
        locked_d = 1'b0;
        rr_ptr_d = next_idx(lock_src_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q       <= 1'b0;
      lock_src_q     <= '0;
      rr_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_sop_q      <= 1'b0;
      out_eop_q      <= 1'b0;
      out_src_q      <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      locked_q       <= locked_d;
      lock_src_q     <= lock_src_d;
      rr_ptr_q       <= rr_ptr_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_sop_q      <= out_sop_d;
      out_eop_q      <= out_eop_d;
      out_src_q      <= out_src_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sop      = out_sop_q;
  assign out_eop      = out_eop_q;
  assign out_src      = out_src_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_ofs_plat_host_chan_tx_tlp_arb.sv
// Purpose : directed self-checking bench for ofs_plat_host_chan_tx_tlp_arb (3 sources, 32-bit beats).
// Latency : outputs sampled 1 time unit after the rising edge; in_ready sampled after inputs settle.
// Backpressure: out_ready is driven directly by the stimulus to create stalls.
module tb_ofs_plat_host_chan_tx_tlp_arb;

  localparam int NUM_SRC = 3;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = $clog2(NUM_SRC);

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_SRC-1:0]        vld;
  logic [NUM_SRC-1:0]        sop;
  logic [NUM_SRC-1:0]        eop;
  logic [DATA_W-1:0]         dat [NUM_SRC];
  logic [NUM_SRC*DATA_W-1:0] in_data;
  logic [NUM_SRC-1:0]        in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_sop;
  logic                      out_eop;
  logic [IDX_W-1:0]          out_src;
  logic                      protocol_err;

  int tests_run = 0;
  int tests_failed = 0;

  assign in_data = {dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  ofs_plat_host_chan_tx_tlp_arb #(
    .NUM_SRC (NUM_SRC),
    .DATA_W  (DATA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (vld),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sop       (sop),
    .in_eop       (eop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_src      (out_src),
    .protocol_err (protocol_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int s, input logic s_sop, input logic s_eop, input logic [DATA_W-1:0] d);
    vld[s] = 1'b1;
    sop[s] = s_sop;
    eop[s] = s_eop;
    dat[s] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vld   = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    vld = '0; sop = '0; eop = '0;
    for (int i = 0; i < NUM_SRC; i++) dat[i] = '0;

    // ---------------- reset state ----------------
    cyc();
    cyc();
    vld = 3'b111; sop = 3'b111; eop = 3'b111;
    #1;
    check("rst_in_ready",   in_ready,     0);
    check("rst_out_valid",  out_valid,    0);
    check("rst_out_sop",    out_sop,      0);
    check("rst_out_eop",    out_eop,      0);
    check("rst_out_src",    out_src,      0);
    check("rst_out_data",   out_data,     0);
    check("rst_perr",       protocol_err, 0);
    do_reset();

    // ---------------- single source, 4 single-beat packets ----------------
    offer(1, 1'b1, 1'b1, 32'hA0);
    #1;
    check("single_in_ready", in_ready, 3'b010);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("single_valid", out_valid, 1);
      check("single_src",   out_src,   1);
      check("single_data",  out_data,  32'hA0 + k);
      dat[1] = 32'hA1 + k;
    end
    vld = '0;
    cyc();
    check("single_drain", out_valid, 0);

    // ---------------- fairness from reset ----------------
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) offer(i, 1'b1, 1'b1, 32'h100 + i);
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("rr_valid", out_valid, 1);
      check("rr_src",   out_src,   k % 3);
      check("rr_data",  out_data,  32'h100 + (k % 3));
    end
    vld = '0;
    cyc();

    // ---------------- lock: src2 3-beat packet vs src0 ----------------
    do_reset();
    offer(2, 1'b1, 1'b0, 32'h200);
    #1;
    check("lock_b0_ready", in_ready, 3'b100);
    cyc();
    check("lock_b0_src", out_src, 2);
    check("lock_b0_sop", out_sop, 1);
    offer(0, 1'b1, 1'b1, 32'h55);
    offer(2, 1'b0, 1'b0, 32'h201);
    #1;
    check("lock_b1_ready", in_ready, 3'b100);
    cyc();
    check("lock_b1_src",  out_src,  2);
    check("lock_b1_data", out_data, 32'h201);
    offer(2, 1'b0, 1'b1, 32'h202);
    #1;
    check("lock_b2_ready", in_ready, 3'b100);
    cyc();
    check("lock_b2_data", out_data, 32'h202);
    check("lock_b2_eop",  out_eop,  1);
    vld[2] = 1'b0;
    #1;
    check("lock_rel_ready", in_ready, 3'b001);
    cyc();
    check("lock_after_src",  out_src,  0);
    check("lock_after_data", out_data, 32'h55);
    vld = '0;
    cyc();

    // ---------------- backpressure during src1 4-beat packet ----------------
    do_reset();
    offer(1, 1'b1, 1'b0, 32'h300);
    cyc();
    offer(1, 1'b0, 1'b0, 32'h301);
    cyc();
    check("bp_b1_data", out_data, 32'h301);
    out_ready = 1'b0;
    offer(1, 1'b0, 1'b0, 32'h302);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      cyc();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data",  out_data,  32'h301);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_ready", in_ready, 3'b010);
    cyc();
    check("bp_b2_data", out_data, 32'h302);
    offer(1, 1'b0, 1'b1, 32'h303);
    cyc();
    check("bp_b3_data", out_data, 32'h303);
    check("bp_b3_eop",  out_eop,  1);
    vld = '0;
    cyc();
    check("bp_drain", out_valid, 0);

    // ---------------- protocol error ----------------
    do_reset();
    offer(0, 1'b0, 1'b1, 32'h400);
    #1;
    check("perr_before", protocol_err, 0);
    cyc();
    check("perr_fwd_valid", out_valid,    1);
    check("perr_fwd_data",  out_data,     32'h400);
    check("perr_set",       protocol_err, 1);
    vld = '0;
    cyc();
    cyc();
    check("perr_sticky", protocol_err, 1);

    // ---------------- reset mid-packet (rr_ptr is 1 here) ----------------
    offer(1, 1'b1, 1'b0, 32'h500);
    cyc();
    check("rmp_b0_src", out_src, 1);
    offer(1, 1'b0, 1'b0, 32'h501);
    cyc();
    check("rmp_b1_data", out_data, 32'h501);
    reset = 1'b1;
    offer(0, 1'b1, 1'b1, 32'h600);
    offer(1, 1'b1, 1'b0, 32'h500);
    #1;
    check("rmp_rst_ready", in_ready, 0);
    cyc();
    check("rmp_valid", out_valid,    0);
    check("rmp_perr",  protocol_err, 0);
    reset = 1'b0;
    #1;
    check("rmp_ready", in_ready, 3'b001);
    cyc();
    check("rmp_src",  out_src,  0);
    check("rmp_data", out_data, 32'h600);
    vld = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
